nibble_serial_adder: RTL and testbench

Sequential wide adder that adds two WIDTH-bit operands four bits per clock through a single instance of the team's 4-bit ripple-carry adder (`Ripple_Carry_adder`). It is the stage that feeds that adder: it accepts operands over a valid/ready handshake, slices them into nibbles LSB-first, chains the carry between cycles in a register, and reassembles the sum. The block sits between an operand producer and a result consumer. It trades latency for area when a full-width ripple chain is too slow or too large.

---
 rtl/nibble_serial_adder.sv | 141 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder: one nibble per clock through a shared 4-bit ripple-carry adder,
// valid/ready on both sides, registered sum/cout/ovf.

module Ripple_Carry_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic [3:0] o_carry
);
    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_carry = w_c[4:1];
endmodule

module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned NIBS = WIDTH / 4;
    localparam int unsigned CNTW = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CNTW-1:0] LAST_NIB = CNTW'(NIBS - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_carry;
    logic [CNTW-1:0]  r_nib_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0]       w_add_sum;
    logic [3:0]       w_add_carry;
    logic [WIDTH-1:0] w_res_next;

    Ripple_Carry_adder u_rca (
        .i_a     (r_a_sh[3:0]),
        .i_b     (r_b_sh[3:0]),
        .i_cin   (r_carry),
        .o_sum   (w_add_sum),
        .o_carry (w_add_carry)
    );

    // Each new nibble enters at the top; after NIBS shifts the LSB nibble sits at bit 0.
    if (NIBS == 1) begin : g_res_single
        assign w_res_next = w_add_sum;
    end else begin : g_res_multi
        assign w_res_next = {w_add_sum, r_res_sh[WIDTH-1:4]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_res_sh  <= '0;
            r_carry   <= 1'b0;
            r_nib_cnt <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a_sh    <= a;
                        r_b_sh    <= b;
                        r_carry   <= cin;
                        r_nib_cnt <= '0;
                        r_state   <= StRun;
                    end
                end
                StRun: begin
                    r_carry   <= w_add_carry[3];
                    r_res_sh  <= w_res_next;
                    r_a_sh    <= r_a_sh >> 4;
                    r_b_sh    <= r_b_sh >> 4;
                    r_nib_cnt <= r_nib_cnt + CNTW'(1);
                    if (r_nib_cnt == LAST_NIB) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_add_carry[3];
                        // Carry into the MSB is bit 2 of the top nibble's carry vector.
                        r_ovf   <= w_add_carry[2] ^ w_add_carry[3];
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle) && !rst;
    assign out_valid = (r_state == StDone);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    property p_hold_result;
        @(posedge clk) disable iff (rst)
            (out_valid && !out_ready) |=>
                (out_valid && $stable(sum) && $stable(cout) && $stable(ovf));
    endproperty
    a_hold_result: assert property (p_hold_result);

    property p_no_overlap;
        @(posedge clk) disable iff (rst) in_ready |-> !out_valid;
    endproperty
    a_no_overlap: assert property (p_no_overlap);
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16 (directed + random) and WIDTH=4 (random).

module tb_nibble_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        rst16 = 1'b1;
    logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    logic        rst4 = 1'b1;
    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst16),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .cout      (cout16),
        .ovf       (ovf16)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    // Expected results packed as {ovf, cout, sum}.
    logic [17:0] q16[$];
    logic [5:0]  q4[$];
    logic [17:0] e16;
    logic [5:0]  e4;

    int unsigned acc16 = 0, acc4 = 0;
    bit          have_prev16 = 0, have_prev4 = 0, chk_ii16 = 0;
    bit          done4 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        logic [16:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {16'd0, c};
        v = (x[15] == y[15]) && (t[15] != x[15]);
        return {v, t[16], t[15:0]};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y,
                                          input logic c);
        logic [4:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {4'd0, c};
        v = (x[3] == y[3]) && (t[3] != x[3]);
        return {v, t[4], t[3:0]};
    endfunction

    // Monitors: acc* is sampled half a cycle before the accepting edge, hence the -1.
    bit pv16 = 0;
    always @(negedge clk) begin
        if (rst16) begin
            q16.delete();
            pv16 = 0;
        end else begin
            if (out_valid16 && !pv16) check("latency16", cyc - acc16 - 1, 4);
            if (out_valid16 && out_ready16) begin
                check("pending16", (q16.size() > 0), 1);
                if (q16.size() > 0) begin
                    e16 = q16.pop_front();
                    check("sum16", sum16, e16[15:0]);
                    check("cout16", cout16, e16[16]);
                    check("ovf16", ovf16, e16[17]);
                end
            end
            pv16 = out_valid16;
        end
    end

    bit pv4 = 0;
    always @(negedge clk) begin
        if (rst4) begin
            q4.delete();
            pv4 = 0;
        end else begin
            if (out_valid4 && !pv4) check("latency4", cyc - acc4 - 1, 1);
            if (out_valid4 && out_ready4) begin
                check("pending4", (q4.size() > 0), 1);
                if (q4.size() > 0) begin
                    e4 = q4.pop_front();
                    check("sum4", sum4, e4[3:0]);
                    check("cout4", cout4, e4[4]);
                    check("ovf4", ovf4, e4[5]);
                end
            end
            pv4 = out_valid4;
        end
    end

    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic c);
        bit got = 0;
        a16 = x; b16 = y; cin16 = c; in_valid16 = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (in_ready16) begin
                got = 1;
                q16.push_back(model16(x, y, c));
                if (chk_ii16 && have_prev16) check("ii16", cyc - acc16, 6);
                acc16 = cyc;
                have_prev16 = 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        check("accept16", got, 1);
    endtask

    task automatic send4(input logic [3:0] x, input logic [3:0] y, input logic c);
        bit got = 0;
        a4 = x; b4 = y; cin4 = c; in_valid4 = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (in_ready4) begin
                got = 1;
                q4.push_back(model4(x, y, c));
                if (have_prev4) check("ii4", cyc - acc4, 3);
                acc4 = cyc;
                have_prev4 = 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        check("accept4", got, 1);
    endtask

    task automatic wait_ov16();
        bit seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid16;
        end
        check("valid16_wait", seen, 1);
    endtask

    task automatic dir16(input logic [15:0] x, input logic [15:0] y, input logic c,
                         input logic [15:0] es, input logic ec, input logic ev);
        send16(x, y, c);
        wait_ov16();
        check("dir_sum16", sum16, es);
        check("dir_cout16", cout16, ec);
        check("dir_ovf16", ovf16, ev);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // WIDTH=4 random stream, independent of the WIDTH=16 sequence.
    initial begin
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
        for (int n = 0; n < 100 && rst4; n++) @(negedge clk);
        check("rst_in_ready4", in_ready4, 1);
        check("rst_out_valid4", out_valid4, 0);
        check("rst_sum4", sum4, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 1000; i++) begin
            send4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end
        done4 = 1;
    end

    initial begin
        bit seen;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold_in_ready16", in_ready16, 0);
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        rst4  = 1'b0;
        @(negedge clk);
        check("rst_in_ready16", in_ready16, 1);
        check("rst_out_valid16", out_valid16, 0);
        check("rst_sum16", sum16, 0);
        check("rst_cout16", cout16, 0);
        check("rst_ovf16", ovf16, 0);
        @(posedge clk);
        #1;

        dir16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        dir16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        dir16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        dir16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: result must hold and new operands must be refused.
        out_ready16 = 1'b0;
        send16(16'h1234, 16'h4321, 1'b0);
        wait_ov16();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a16 = 16'($urandom); b16 = 16'($urandom); in_valid16 = (i % 2 == 0);
            @(negedge clk);
            check("bp_in_ready16", in_ready16, 0);
            check("bp_out_valid16", out_valid16, 1);
            check("bp_sum16", sum16, 16'h5555);
        end
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_in_ready16", in_ready16, 1);
        check("bp_release_out_valid16", out_valid16, 0);
        @(posedge clk);
        #1;

        // Abort mid-run; handshake presented during reset must be ignored.
        send16(16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst16 = 1'b1;
        in_valid16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222;
        @(negedge clk);
        check("rst_wins_in_ready16", in_ready16, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_out_valid16", out_valid16, 0);
        check("abort_sum16", sum16, 0);
        check("abort_cout16", cout16, 0);
        check("abort_ovf16", ovf16, 0);
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        in_valid16 = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen |= out_valid16;
        end
        check("abort_no_valid16", seen, 0);
        @(posedge clk);
        #1;
        dir16(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

        have_prev16 = 0;
        chk_ii16 = 1;
        for (int i = 0; i < 1000; i++) begin
            send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        chk_ii16 = 0;

        for (int n = 0; n < 20000 && !done4; n++) @(negedge clk);
        check("done4", done4, 1);
        repeat (12) @(negedge clk);
        check("drain16", q16.size(), 0);
        check("drain4", q4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
